// File: rtl/cla_wide_seq.sv
// cla_wide_seq: WORDS x N-bit add (optionally subtract) sequenced through one
// shared external combinational N-bit adder, least-significant word first,
// with the inter-word carry held in a register.
//
// Optional feature macro: CLA_WIDE_SUB_EN (adds in_sub, computes A + ~B + 1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b operands (W bits)
//   in_sub                subtract request (CLA_WIDE_SUB_EN only)
//   out_valid/out_ready   result handshake; out_sum (W bits), out_cout
//   busy                  high while a transaction is running or waiting
//   adder_a/b/cin         word operands and carry to the external adder
//   adder_sum/cout        combinational result from the external adder
module cla_wide_seq #(
    parameter int unsigned N     = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDS*N-1:0]   in_a,
    input  logic [WORDS*N-1:0]   in_b,
`ifdef CLA_WIDE_SUB_EN
    input  logic                 in_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDS*N-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 busy,
    output logic [N-1:0]         adder_a,
    output logic [N-1:0]         adder_b,
    output logic                 adder_cin,
    input  logic [N-1:0]         adder_sum,
    input  logic                 adder_cout
);

    localparam int unsigned W  = WORDS * N;
    localparam int unsigned IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic          sub_q;
    logic [W-1:0]  a_q, b_q;
    logic          sub_in_c;

`ifdef CLA_WIDE_SUB_EN
    assign sub_in_c = in_sub;
`else
    assign sub_in_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    if (out_ready)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Registered handshake/status flags follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Operand latch, word index, inter-word carry and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        sub_q   <= sub_in_c;
                        idx_q   <= '0;
                        carry_q <= sub_in_c;   // +1 of two's complement
                    end
                end
                RUN: begin
                    out_sum[idx_q*N +: N] <= adder_sum;
                    carry_q               <= adder_cout;
                    // Index saturates on the last word; reloaded on next accept
                    if (idx_q == LAST) out_cout <= adder_cout;
                    else               idx_q    <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Word selection toward the external adder; quiet outside RUN
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (state_q == RUN) begin
            adder_a   = a_q[idx_q*N +: N];
            adder_b   = sub_q ? ~b_q[idx_q*N +: N] : b_q[idx_q*N +: N];
            adder_cin = carry_q;
        end
    end

endmodule

// File: tb/tb_cla_wide_seq.sv
module tb_cla_wide_seq;
    localparam int N     = 16;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
`ifdef CLA_WIDE_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic [N-1:0] adder_a, adder_b, adder_sum;
    logic         adder_cin, adder_cout;

    int tests  = 0;
    int failed = 0;

    logic [N-1:0] tr_a   [WORDS];
    logic [N-1:0] tr_b   [WORDS];
    logic         tr_cin [WORDS];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        string        name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // External combinational adder
    always_comb {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + 17'(adder_cin);

    cla_wide_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
`ifdef CLA_WIDE_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    // Reference: whole-width arithmetic modulo 2^W with raw carry
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic s);
`ifdef CLA_WIDE_SUB_EN
        in_sub = s;
`else
        if (s) $display("note: subtract vector skipped in add-only build");
`endif
    endtask

    // One full transaction; hold = cycles of backpressure in DONE
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           input int hold, output logic [W-1:0] sum, output logic cout,
                           output int lat);
        int k = 0;
        in_a = a; in_b = b; set_sub(sub); in_valid = 1'b1;
        while (!in_ready && k < 50) begin step(); k++; end
        if (!in_ready) check("accept_timeout", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        set_sub(1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < WORDS) begin
                tr_a[lat] = adder_a; tr_b[lat] = adder_b; tr_cin[lat] = adder_cin;
            end
            step();
            lat++;
        end
        repeat (hold) step();
        sum  = out_sum;
        cout = out_cout;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] sum, ref_sum, big;
        logic         cout;
        logic [W:0]   r;
        int           lat;
        int           acc_cyc[2];
        int           n_acc, n_res, cyc;
        logic [W-1:0] res[2];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; set_sub(1'b0);
        #12;
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_sum",   out_sum,       W'(0));
        check("rst_out_cout",  W'(out_cout),  W'(0));
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_adder",     W'({adder_a, adder_b, adder_cin}), W'(0));
        rst_n = 1'b1;
        step();

        // Directed table
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "ripple"});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, "overflow"});
        vecs.push_back('{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, "small"});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, "msb_carry"});
        vecs.push_back('{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, "long_ripple"});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, "mixed"});
`ifdef CLA_WIDE_SUB_EN
        vecs.push_back('{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_borrow"});
        vecs.push_back('{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, "sub_pos"});
`endif
        foreach (vecs[i]) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].sub, 0, sum, cout, lat);
            check({vecs[i].name, "_sum"},  sum,     vecs[i].sum);
            check({vecs[i].name, "_cout"}, W'(cout), W'(vecs[i].cout));
            check({vecs[i].name, "_lat"},  W'(lat),  W'(WORDS));
        end

        // Adder word sequence during a full-overflow add
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, sum, cout, lat);
        for (int i = 0; i < WORDS; i++) begin
            check($sformatf("ovf_adder_a%0d", i), W'(tr_a[i]), W'(16'hFFFF));
            check($sformatf("ovf_adder_b%0d", i), W'(tr_b[i]), W'(i == 0 ? 1 : 0));
            check($sformatf("ovf_cin%0d", i),     W'(tr_cin[i]), W'(i == 0 ? 0 : 1));
        end
        check("idle_adder_a", W'(adder_a), W'(0));

        // Backpressure with ignored input pulses
        in_a = 64'h0000_0001_0000_0002; in_b = 64'h0000_0003_0000_0004; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        check("bp_lat", W'(lat), W'(WORDS));
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            step();
            check($sformatf("bp_valid%0d", c), W'(out_valid), W'(1));
            check($sformatf("bp_ready%0d", c), W'(in_ready),  W'(0));
            check($sformatf("bp_sum%0d", c),   out_sum, 64'h0000_0004_0000_0006);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_consumed", W'(out_valid), W'(0));
        n_res = 0;
        repeat (WORDS + 3) begin
            step();
            if (out_valid || busy) n_res++;
        end
        check("bp_single_result", W'(n_res), W'(0));

        // Reset in the middle of RUN (idx==2)
        in_a = 64'h1111_2222_3333_4444; in_b = 64'h1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", W'(out_valid), W'(0));
        check("mrst_in_ready",  W'(in_ready),  W'(1));
        check("mrst_out_sum",   out_sum,       W'(0));
        check("mrst_busy",      W'(busy),      W'(0));
        #2;
        rst_n = 1'b1;
        step();
        run_txn(64'h3, 64'h4, 1'b0, 0, sum, cout, lat);
        check("mrst_after_sum", sum, 64'h7);

        // Back-to-back with in_valid and out_ready held high
        in_a = 64'h1; in_b = 64'h2; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_res = 0; cyc = 0;
        while (n_res < 2 && cyc < 40) begin
            if (in_valid && in_ready && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
            if (out_valid && n_res < 2) begin res[n_res] = out_sum; n_res++; end
            step();
            cyc++;
            if (n_acc == 1) begin in_a = 64'd10; in_b = 64'd20; end
            if (n_acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_results", W'(n_res), W'(2));
        check("b2b_accepts", W'(n_acc), W'(2));
        if (n_res == 2) begin
            check("b2b_sum0", res[0], 64'd3);
            check("b2b_sum1", res[1], 64'd30);
        end
        if (n_acc == 2) check("b2b_interval", W'(acc_cyc[1] - acc_cyc[0]), W'(WORDS + 2));
        step();

        // Randomized transactions against the reference
        for (int t = 0; t < 40; t++) begin
            logic s;
            big = {$urandom, $urandom};
            ref_sum = {$urandom, $urandom};
            if (t % 5 == 0) big = '1;
`ifdef CLA_WIDE_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            r = model(big, ref_sum, s);
            run_txn(big, ref_sum, s, $urandom_range(0, 3), sum, cout, lat);
            check($sformatf("rnd%0d_sum", t),  sum,      r[W-1:0]);
            check($sformatf("rnd%0d_cout", t), W'(cout), W'(r[W]));
            check($sformatf("rnd%0d_lat", t),  W'(lat),  W'(WORDS));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cla_wide_seq.md
# cla_wide_seq

Multi-cycle sequencer that performs WORDS×N-bit additions by driving one shared external N-bit carry-lookahead adder a word at a time, least-significant word first, with the carry registered between words. It sits between a valid/ready operand source and result sink and the adder datapath. Result width scales without growing the adder.

## Interface

Parameters:
- N, 16, adder word width in bits.
- WORDS, 4, words per operand, at least 2; operand width W = WORDS*N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  subtract request; present only with CLA_WIDE_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_sum  out  W  result.
- out_cout  out  1  final carry out of the MSB word.
- busy  out  1  high in RUN or DONE.
- adder_a  out  N  word to adder input A.
- adder_b  out  N  word to adder input B.
- adder_cin  out  1  carry into adder.
- adder_sum  in  N  combinational adder sum.
- adder_cout  in  1  combinational adder carry out.

## Operation

- The external adder is combinational: adder_sum/adder_cout settle within the same cycle as adder_a/adder_b/adder_cin.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b, and in_sub.
  - Set idx=0 and carry=0, or carry=1 when subtracting.
  - Go to RUN.
- RUN:
  - adder_a = A[idx*N +: N]; adder_b = B word idx, inverted when subtracting; adder_cin = carry.
  - Each edge: store adder_sum into result word idx, carry<=adder_cout, idx<=idx+1.
  - On the edge with idx==WORDS-1: out_cout<=adder_cout and go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - On out_valid&&out_ready, go to IDLE.
- in_ready and in_valid interaction:
  - in_ready=0 in RUN and DONE.
  - in_valid in those states is ignored and not queued.
- Outside RUN, adder_a/adder_b/adder_cin drive 0.
- Arithmetic is modulo 2^W. out_cout is the raw carry; for subtraction, 0 means borrow.
- idx is ceil(log2(WORDS)) bits wide and never wraps, because exit happens at WORDS-1.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, adder_a/adder_b/adder_cin=0, idx=0, carry=0.
- Reset is asynchronous. Asserting it mid-RUN or mid-DONE aborts immediately, discards the partial result, and applies the reset values.
- Latency: out_valid rises exactly WORDS clock edges after the accept edge.
- Back-to-back:
  - The DONE→IDLE handshake edge and the next accept cannot share a cycle.
  - Minimum initiation interval is WORDS+2 cycles with out_ready held high.
- out_ready high before DONE has no effect.
- Backpressure: DONE persists indefinitely while out_ready=0, with outputs unchanged.
- in_a/in_b may change freely after the accept edge; only latched copies are used.

## Configuration

- CLA_WIDE_SUB_EN defined:
  - in_sub port exists.
  - Subtraction is A + ~B + 1, using inverted B words and initial carry 1.
- CLA_WIDE_SUB_EN undefined:
  - No in_sub port.
  - Addition only; initial carry is always 0 and B is never inverted.

## Test plan

(N=16, WORDS=4.)
- Carry ripple: A=0x0000_0000_0000_FFFF, B=1 → out_sum=0x0000_0000_0001_0000, out_cout=0, out_valid exactly 4 edges after accept.
- Full overflow: A=0xFFFF_FFFF_FFFF_FFFF, B=1 → out_sum=0, out_cout=1. Adder inputs per RUN cycle show word i with adder_cin=0,1,1,1.
- Backpressure and ignored input: out_ready held 0 for 5 cycles in DONE while in_valid pulses. out_sum stays stable, in_ready stays 0, and exactly one result is delivered when out_ready rises.
- Reset mid-operation: assert rst_n=0 during RUN at idx=2 → out_valid=0, in_ready=1, out_sum=0 immediately. A new A=3, B=4 then yields out_sum=7.
- Back-to-back: two transactions (A=1, B=2 then A=10, B=20) with in_valid and out_ready held high → results 3 then 30, accept edges 6 cycles apart.
- With CLA_WIDE_SUB_EN: in_sub=1, A=5, B=7 → out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0. A=7, B=5 → out_sum=2, out_cout=1.
